// File: rtl/datapath_controller_if.sv
// Control/instruction bus between the instruction source, datapath_controller
// and the register-file/shifter/ALU datapath.
interface datapath_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic        illegal;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] datapath_in;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  // Controller end: takes instructions, drives every datapath control.
  modport master (
    input  in, load, s,
    output w, illegal, readnum, writenum, write, vsel, datapath_in,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );

  // Instruction source / datapath end.
  modport slave (
    output in, load, s,
    input  w, illegal, readnum, writenum, write, vsel, datapath_in,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );
endinterface

// File: rtl/datapath_controller.sv
// Instruction register, decoder and control FSM for the 16-bit
// register-file/shifter/ALU datapath. One instruction per start pulse.
module datapath_controller (
  input  logic           clk,
  input  logic           rst_n,
  datapath_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
  } state_t;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic [15:0] datapath_in;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       ctrl_q;

  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_movi, is_movr, is_alu, is_cmp, is_mvn;

  assign opcode  = ir_q[15:13];
  assign op      = ir_q[12:11];
  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);

  // Moore output decode for a given state and instruction word.
  function automatic ctrl_t decode(input state_t st, input logic [15:0] ir);
    ctrl_t      c;
    logic [2:0] f_opc;
    logic [1:0] f_op;
    logic       f_movr, f_cmp, f_legal;
    c       = '0;
    f_opc   = ir[15:13];
    f_op    = ir[12:11];
    f_movr  = (f_opc == 3'b110) && (f_op == 2'b00);
    f_cmp   = (f_opc == 3'b101) && (f_op == 2'b01);
    f_legal = (f_opc == 3'b101) ||
              ((f_opc == 3'b110) && ((f_op == 2'b10) || (f_op == 2'b00)));
    c.datapath_in = {{8{ir[7]}}, ir[7:0]};
    case (st)
      S_WAIT:      c.w = 1'b1;
      S_DECODE:    c.illegal = !f_legal;
      S_WRITE_IMM: begin
        c.writenum = ir[10:8];
        c.vsel     = 1'b1;
        c.write    = 1'b1;
      end
      S_GET_A: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = ir[4:3];
        c.asel  = f_movr;
        c.ALUop = f_movr ? 2'b00 : f_op;
        c.loadc = !f_cmp;
        c.loads = f_cmp;
      end
      S_WRITE_REG: begin
        c.writenum = ir[7:5];
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state and IR capture (IR writable only while idle in WAIT).
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (bus.load) ir_d = bus.in;
        if (bus.s)    state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)                state_d = S_WRITE_IMM;
        else if (is_movr || is_mvn) state_d = S_GET_B;
        else if (is_alu)            state_d = S_GET_A;
        else                        state_d = S_WAIT;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // State, IR and registered controls. Outputs are decoded from the
  // next state/IR so they stay cycle-identical to a Moore decode of the
  // current state while coming straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ctrl_q  <= decode(S_WAIT, '0);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= decode(state_d, ir_d);
    end
  end

  assign bus.w           = ctrl_q.w;
  assign bus.illegal     = ctrl_q.illegal;
  assign bus.readnum     = ctrl_q.readnum;
  assign bus.writenum    = ctrl_q.writenum;
  assign bus.write       = ctrl_q.write;
  assign bus.vsel        = ctrl_q.vsel;
  assign bus.datapath_in = ctrl_q.datapath_in;
  assign bus.loada       = ctrl_q.loada;
  assign bus.loadb       = ctrl_q.loadb;
  assign bus.loadc       = ctrl_q.loadc;
  assign bus.loads       = ctrl_q.loads;
  assign bus.asel        = ctrl_q.asel;
  assign bus.bsel        = ctrl_q.bsel;
  assign bus.shift       = ctrl_q.shift;
  assign bus.ALUop       = ctrl_q.ALUop;

endmodule
